rmt_ingress_arbiter: RTL and testbench

// Frame-atomic round-robin arbiter that shares the single ingress of the RMT match stage between PORT_COUNT
// AXI-stream sources. It grants one source at a time for a whole frame and forwards beats through a

---
 rtl/rmt_ingress_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rmt_ingress_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ingress_arbiter.sv
// rmt_ingress_arbiter
// Frame-atomic round-robin arbiter in front of the RMT match stage. One source
// port owns the ingress for a whole frame; beats pass through a single
// registered output stage and carry their source index on m_axis_tid.
//
// state  | meaning
// IDLE   | no frame owner; pick next requester after last_grant (1 cycle)
// ACTIVE | granted port forwards beats until its tlast beat is accepted

module rmt_ingress_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH  = 8,
    parameter int PORT_COUNT  = 4,
    parameter int ID_WIDTH    = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [COUNT_WIDTH-1:0]           frame_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   grant, grant_nxt;
    logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;

    logic                  arb_found;
    logic [ID_WIDTH-1:0]   arb_pick;
    logic                  hi_found, lo_found;
    logic [ID_WIDTH-1:0]   hi_pick, lo_pick;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_valid;
    logic                  sel_last;

    logic                  out_ready;
    logic                  accept;

    // The output register can take a beat when it is empty or being drained.
    assign out_ready = !m_axis_tvalid || m_axis_tready;

    // Round-robin pick: lowest requester above last_grant, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_pick  = ID_WIDTH'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_pick  = ID_WIDTH'(i);
                end
            end
        end
        arb_found = hi_found || lo_found;
        arb_pick  = hi_found ? hi_pick : lo_pick;
    end

    // Select the granted source's beat.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Next-state, grant bookkeeping and source ready generation.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        s_axis_tready  = '0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_pick;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                for (int i = 0; i < PORT_COUNT; i++) begin
                    if (grant == ID_WIDTH'(i)) begin
                        s_axis_tready[i] = out_ready;
                    end
                end
                accept = sel_valid && out_ready;
                if (accept && sel_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset gives port 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(PORT_COUNT - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Output register: load accepted beats, drop valid once drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tid    <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
            m_axis_tuser  <= sel_user;
            m_axis_tid    <= grant;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Count frames as their tlast beat is taken from the source; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (accept && sel_last) begin
            frame_count <= frame_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Testbench for rmt_ingress_arbiter: per-port expected-beat queues filled by the
// stimulus tasks, a monitor that pops and compares every output beat, plus
// directed latency/ordering/reset checks and a randomized multi-port phase.

module tb_rmt_ingress_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 8;
    localparam int PC = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [PC*DW-1:0] s_tdata;
    logic [PC*KW-1:0] s_tkeep;
    logic [PC-1:0]    s_tvalid;
    logic [PC-1:0]    s_tready;
    logic [PC-1:0]    s_tlast;
    logic [PC*UW-1:0] s_tuser;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [UW-1:0]    m_tuser;
    logic [IW-1:0]    m_tid;
    logic [CW-1:0]    frame_count;

    logic [DW-1:0] src_data  [PC];
    logic [KW-1:0] src_keep  [PC];
    logic [UW-1:0] src_user  [PC];
    logic          src_valid [PC];
    logic          src_last  [PC];

    rmt_ingress_arbiter #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .PORT_COUNT (PC),
        .ID_WIDTH   (IW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .m_axis_tid   (m_tid),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < PC; i++) begin
            s_tdata[i*DW +: DW] = src_data[i];
            s_tkeep[i*KW +: KW] = src_keep[i];
            s_tuser[i*UW +: UW] = src_user[i];
            s_tvalid[i]         = src_valid[i];
            s_tlast[i]          = src_last[i];
        end
    end

    int    n_total = 0;
    int    n_pass  = 0;
    int    cyc     = 0;
    int    model_frames = 0;
    int    ready_mode = 0;
    bit    fix_data = 1'b0;
    bit    check_gaps = 1'b0;
    bit    gap_armed = 1'b0;

    beat_t exp_q [PC][$];
    int    frame_tids[$];
    int    rise_cyc  [PC];
    int    first_acc [PC];
    int    last_acc  [PC];
    int    first_out [PC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Downstream ready: always 1, strict 1/0 toggle, or random.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the expected beat of the tagged port on every output handshake.
    initial begin : monitor
        bit    in_frame = 1'b0;
        int    cur_tid = 0;
        int    prev_cyc = 0;
        bit    prev_stall = 1'b0;
        logic [63:0] prev_d = '0;
        logic [63:0] prev_side = '0;
        beat_t e;
        int    t;
        forever begin
            @(negedge clk);
            if (s_tready != '0)
                check("tready_onehot", 64'($onehot(s_tready)), 64'(1));
            if (m_tvalid && !m_tready)
                check("stall_blocks_tready", 64'(s_tready), 64'(0));
            if (prev_stall && !rst) begin
                check("hold_data", m_tdata, prev_d);
                check("hold_side", 64'({m_tvalid, m_tkeep, m_tuser, m_tid, m_tlast}), prev_side);
            end
            if (m_tvalid && m_tready) begin
                t = int'(m_tid);
                if (in_frame) begin
                    check("no_interleave", 64'(t), 64'(cur_tid));
                    if (check_gaps) check("intra_frame_gap", 64'(cyc - prev_cyc), 64'(1));
                end else begin
                    frame_tids.push_back(t);
                    first_out[t] = cyc;
                    if (check_gaps && gap_armed)
                        check("inter_frame_gap", 64'(cyc - prev_cyc), 64'(2));
                end
                if (exp_q[t].size() == 0) begin
                    check("unexpected_beat_port", 64'(t), 64'(PC));
                end else begin
                    e = exp_q[t].pop_front();
                    check("beat_data", m_tdata, e.d);
                    check("beat_keep_user_last", 64'({m_tkeep, m_tuser, m_tlast}), 64'({e.k, e.u, e.l}));
                end
                in_frame  = !m_tlast;
                cur_tid   = t;
                prev_cyc  = cyc;
                gap_armed = check_gaps && m_tlast;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_side  = 64'({m_tvalid, m_tkeep, m_tuser, m_tid, m_tlast});
            if (rst) begin
                in_frame   = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_accept(input int p, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (s_tready[p] && src_valid[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout_port", 64'(p), 64'(PC));
    endtask

    task automatic make_beat(input bit lst, output beat_t b);
        if (fix_data) begin
            b.d = 64'h1111_1111_1111_1111;
            b.k = 8'hFF;
        end else begin
            b.d = {$urandom, $urandom};
            b.k = KW'($urandom);
        end
        b.u = UW'($urandom);
        b.l = lst;
    endtask

    task automatic drive_beat(input int p, input beat_t b);
        src_data[p]  = b.d;
        src_keep[p]  = b.k;
        src_user[p]  = b.u;
        src_last[p]  = b.l;
        src_valid[p] = 1'b1;
    endtask

    // Send one frame from port p; called aligned just after a rising edge.
    task automatic send_frame(input int p, input int len, input int bub_at, input int bub_len);
        beat_t beats[$];
        beat_t b;
        bit    ok;
        for (int k = 0; k < len; k++) begin
            make_beat(k == len - 1, b);
            beats.push_back(b);
            exp_q[p].push_back(b);
        end
        for (int k = 0; k < len; k++) begin
            if (k == bub_at && bub_len > 0) begin
                src_valid[p] = 1'b0;
                repeat (bub_len) @(posedge clk);
                #1;
            end
            drive_beat(p, beats[k]);
            if (k == 0) rise_cyc[p] = cyc;
            wait_accept(p, ok);
            if (!ok) begin
                src_valid[p] = 1'b0;
                return;
            end
            if (k == 0) first_acc[p] = cyc;
            if (beats[k].l) begin
                last_acc[p] = cyc;
                model_frames++;
            end
            @(posedge clk);
            #1;
        end
        src_valid[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < PC; p++) src_valid[p] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_frames = 0;
        for (int p = 0; p < PC; p++) exp_q[p].delete();
    endtask

    initial begin : stimulus
        int    pend[PC];
        int    exp_order[$];
        int    last;
        int    remaining;
        int    c;
        beat_t fb[6];
        bit    ok;

        for (int p = 0; p < PC; p++) begin
            src_data[p] = '0; src_keep[p] = '0; src_user[p] = '0;
            src_valid[p] = 1'b0; src_last[p] = 1'b0;
        end

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_frame_count", 64'(frame_count), 64'(0));
        check("rst_m_tdata", m_tdata, 64'(0));
        check("rst_m_side", 64'({m_tkeep, m_tuser, m_tid, m_tlast}), 64'(0));

        // Single-beat frame latency from port 0
        @(posedge clk);
        #1;
        frame_tids.delete();
        fix_data = 1'b1;
        send_frame(0, 1, -1, 0);
        fix_data = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_latency", 64'(first_out[0] - rise_cyc[0]), 64'(2));
        check("t1_frames_out", 64'(frame_tids.size()), 64'(1));
        if (frame_tids.size() > 0) check("t1_tid", 64'(frame_tids[0]), 64'(0));
        check("t1_frame_count", 64'(frame_count), 64'(1));

        // All ports backlogged with 3-beat frames; port 0 has two
        do_reset();
        frame_tids.delete();
        check_gaps = 1'b1;
        gap_armed  = 1'b0;
        fork
            begin send_frame(0, 3, -1, 0); send_frame(0, 3, -1, 0); end
            send_frame(1, 3, -1, 0);
            send_frame(2, 3, -1, 0);
            send_frame(3, 3, -1, 0);
        join
        repeat (4) @(negedge clk);
        check_gaps = 1'b0;
        pend = '{2, 1, 1, 1};
        last = PC - 1;
        remaining = 5;
        exp_order.delete();
        while (remaining > 0) begin
            for (int s = 1; s <= PC; s++) begin
                c = (last + s) % PC;
                if (pend[c] > 0) begin
                    exp_order.push_back(c);
                    pend[c]--;
                    remaining--;
                    last = c;
                    break;
                end
            end
        end
        check("t2_frames_out", 64'(frame_tids.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < frame_tids.size(); i++)
            check("t2_frame_order", 64'(frame_tids[i]), 64'(exp_order[i]));
        check("t2_frame_count", 64'(frame_count), 64'(model_frames % 16));

        // 8-beat frame from port 2 under 1/0 toggling downstream ready
        do_reset();
        ready_mode = 1;
        send_frame(2, 8, -1, 0);
        repeat (4) @(negedge clk);
        ready_mode = 0;
        check("t3_all_beats_out", 64'(exp_q[2].size()), 64'(0));
        check("t3_frame_count", 64'(frame_count), 64'(1));

        // Port 1 bubble mid-frame while port 3 requests
        do_reset();
        fork
            send_frame(1, 6, 2, 5);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_frame(3, 2, -1, 0);
            end
        join
        repeat (3) @(negedge clk);
        check("t4_port3_after_port1", 64'(first_acc[3] - last_acc[1]), 64'(2));
        check("t4_queues_empty", 64'(exp_q[1].size() + exp_q[3].size()), 64'(0));
        check("t4_frame_count", 64'(frame_count), 64'(2));

        // Reset on beat 3 of a 6-beat frame from port 2
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) make_beat(k == 5, fb[k]);
        exp_q[2].push_back(fb[0]);
        exp_q[2].push_back(fb[1]);
        for (int k = 0; k < 2; k++) begin
            drive_beat(2, fb[k]);
            wait_accept(2, ok);
            @(posedge clk);
            #1;
        end
        drive_beat(2, fb[2]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid[2] = 1'b0;
        model_frames = 0;
        @(negedge clk);
        check("t5_m_tvalid", 64'(m_tvalid), 64'(0));
        check("t5_s_tready", 64'(s_tready), 64'(0));
        check("t5_frame_count", 64'(frame_count), 64'(0));
        check("t5_partial_beats_out", 64'(exp_q[2].size()), 64'(0));
        exp_q[2].delete();
        @(posedge clk);
        #1;
        frame_tids.delete();
        fork
            send_frame(0, 1, -1, 0);
            send_frame(2, 1, -1, 0);
        join
        repeat (3) @(negedge clk);
        check("t5_frames_out", 64'(frame_tids.size()), 64'(2));
        if (frame_tids.size() >= 2) begin
            check("t5_first_port0", 64'(frame_tids[0]), 64'(0));
            check("t5_second_port2", 64'(frame_tids[1]), 64'(2));
        end
        check("t5_frame_count_after", 64'(frame_count), 64'(2));

        // 17 single-beat frames wrap a 4-bit counter
        do_reset();
        for (int f = 0; f < 17; f++) send_frame(int'($urandom_range(0, PC - 1)), 1, -1, 0);
        repeat (3) @(negedge clk);
        check("t6_frame_count_wrap", 64'(frame_count), 64'(model_frames % 16));
        check("t6_frame_count_is_1", 64'(frame_count), 64'(1));

        // Randomized: all ports, random lengths, bubbles and downstream stalls
        do_reset();
        ready_mode = 2;
        for (int p = 0; p < PC; p++) begin
            automatic int pp = p;
            fork
                begin
                    int len;
                    for (int j = 0; j < 6; j++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #1;
                        len = int'($urandom_range(1, 5));
                        send_frame(pp, len, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
                    end
                end
            join_none
        end
        wait fork;
        ready_mode = 0;
        repeat (5) @(negedge clk);
        for (int p = 0; p < PC; p++)
            check("rand_queue_drained", 64'(exp_q[p].size()), 64'(0));
        check("rand_frame_count", 64'(frame_count), 64'(model_frames % 16));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
